// File: rtl/pim_dma_cmd_queue_if.sv
// Core-to-queue PIM command channel: valid/ready handshake plus command operands.
interface pim_dma_cmd_queue_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_funct3;
  logic [3:0]  i_cmd_sel_pim;
  logic [12:0] i_cmd_size;
  logic [31:0] i_cmd_addr;

  modport master (
    output i_cmd_valid, i_cmd_funct3, i_cmd_sel_pim, i_cmd_size, i_cmd_addr,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd_funct3, i_cmd_sel_pim, i_cmd_size, i_cmd_addr,
    output o_cmd_ready
  );
endinterface

// File: rtl/pim_dma_cmd_queue.sv
// PIM DMA command queue: FIFO of core commands issued one at a time to the DMA.
// Optional macro PIM_CMD_CHECK_EN drops illegal commands at pop and raises sticky o_err.
module pim_dma_cmd_queue #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pim_dma_cmd_queue_if.slave  cmd_if,
  output logic                o_dma_en,
  output logic [2:0]          o_funct3,
  output logic [3:0]          o_sel_pim,
  output logic [12:0]         o_size,
  output logic [31:0]         o_mem_addr,
  input  logic                i_dma_busy,
  output logic                o_cmd_done,
  output logic                o_queue_full,
  output logic                o_queue_empty,
  output logic                o_idle,
  output logic                o_err,
  input  logic                i_err_clr
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W   = PTR_W - 1;
  localparam int ENTRY_W = 3 + 4 + 13 + 32;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3
  } state_e;

`ifdef PIM_CMD_CHECK_EN
  function automatic logic cmd_legal(input logic [2:0] funct3, input logic [12:0] size);
    logic op_ok;
    op_ok = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100);
    return op_ok && (size != 13'd0);
  endfunction
`endif

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
  logic [ENTRY_W-1:0]   op_q, op_d;
  logic                 dma_en_q, dma_en_d;
  logic                 err_q, err_d;
  logic                 full_s, empty_s, push_s, done_s, err_set_s;
  logic [ENTRY_W-1:0]   head_s, in_entry_s;

  assign full_s     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_s    = (wr_ptr_q == rd_ptr_q);
  assign push_s     = cmd_if.i_cmd_valid && !full_s;
  assign head_s     = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign in_entry_s = {cmd_if.i_cmd_funct3, cmd_if.i_cmd_sel_pim, cmd_if.i_cmd_size, cmd_if.i_cmd_addr};

  // FIFO write side; a pop in the same cycle never frees room for a push into a full FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = in_entry_s;
      wr_ptr_d                   = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Issue FSM: pop in IDLE, strobe in ISSUE, then track DMA busy rise and fall
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    op_d      = op_q;
    done_s    = 1'b0;
    err_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef PIM_CMD_CHECK_EN
          if (cmd_legal(head_s[51:49], head_s[44:32])) begin
            op_d    = head_s;
            state_d = ST_ISSUE;
          end else begin
            err_set_s = 1'b1;
            state_d   = ST_IDLE;
          end
`else
          op_d    = head_s;
          state_d = ST_ISSUE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (i_dma_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_dma_busy) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe register and sticky error (set has priority over clear)
  always_comb begin
    dma_en_d = (state_d == ST_ISSUE);
`ifdef PIM_CMD_CHECK_EN
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
`else
    err_d = err_q & ~i_err_clr & err_set_s;
`endif
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      op_q     <= '0;
      dma_en_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      op_q     <= op_d;
      dma_en_q <= dma_en_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

  assign cmd_if.o_cmd_ready = !full_s;
  assign o_dma_en           = dma_en_q;
  assign {o_funct3, o_sel_pim, o_size, o_mem_addr} = op_q;
  assign o_cmd_done         = done_s;
  assign o_queue_full       = full_s;
  assign o_queue_empty      = empty_s;
  assign o_idle             = empty_s && (state_q == ST_IDLE);
  assign o_err              = err_q;
endmodule

// File: tb/tb_pim_dma_cmd_queue.sv
// Directed bench for pim_dma_cmd_queue: scoreboard of issued commands, DMA busy model, immediate assertions.
module tb_pim_dma_cmd_queue;
  logic clk;
  logic rst_n;
  logic dma_busy;
  logic err_clr;
  logic dma_en, cmd_done, q_full, q_empty, idle, err;
  logic [2:0]  funct3;
  logic [3:0]  sel_pim;
  logic [12:0] size;
  logic [31:0] mem_addr;

  pim_dma_cmd_queue_if cmd_if();

  pim_dma_cmd_queue #(.FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .cmd_if(cmd_if),
    .o_dma_en(dma_en), .o_funct3(funct3), .o_sel_pim(sel_pim), .o_size(size),
    .o_mem_addr(mem_addr), .i_dma_busy(dma_busy), .o_cmd_done(cmd_done),
    .o_queue_full(q_full), .o_queue_empty(q_empty), .o_idle(idle),
    .o_err(err), .i_err_clr(err_clr)
  );

  typedef struct packed {
    logic [2:0]  f;
    logic [3:0]  s;
    logic [12:0] z;
    logic [31:0] a;
  } cmd_t;

  cmd_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int busy_len = 40;
  bit b2b_chk = 1'b0;
  bit last_done_v = 1'b0;
  int last_done_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DMA model: busy rises the cycle after the strobe and stays high busy_len cycles
  initial begin
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt = 0;
    dma_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        cnt = 0;
        dma_busy = 1'b0;
      end else if (pend) begin
        pend = 1'b0;
        cnt = busy_len;
        dma_busy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) dma_busy = 1'b0;
      end
      if (rst_n && dma_en) pend = 1'b1;
    end
  end

  // Output monitor: issue order against the scoreboard, strobe spacing, completion count
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (cmd_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        last_done_v = 1'b1;
      end
      if (dma_en) begin
        en_cnt++;
        chk("en_while_busy", 64'(dma_busy), 64'(0));
        if (b2b_chk && last_done_v) chk("b2b_gap", 64'(cyc - last_done_cyc), 64'(2));
        chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          cmd_t exp_c;
          exp_c = sb.pop_front();
          chk("issue_operands", 64'({funct3, sel_pim, size, mem_addr}), 64'(exp_c));
        end
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [3:0] s, input logic [12:0] z,
                      input logic [31:0] a, input bit expect_issue);
    int n;
    cmd_t c;
    n = 0;
    @(negedge clk);
    cmd_if.i_cmd_valid = 1'b1;
    cmd_if.i_cmd_funct3 = f;
    cmd_if.i_cmd_sel_pim = s;
    cmd_if.i_cmd_size = z;
    cmd_if.i_cmd_addr = a;
    #1;
    while (!cmd_if.o_cmd_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", 64'(n < 300), 64'(1));
    c = '{f: f, s: s, z: z, a: a};
    if (expect_issue) sb.push_back(c);
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("done_timeout", 64'(done_cnt >= target), 64'(1));
  endtask

  task automatic chk_reset();
    chk("rst_empty", 64'(q_empty), 64'(1));
    chk("rst_full", 64'(q_full), 64'(0));
    chk("rst_ready", 64'(cmd_if.o_cmd_ready), 64'(1));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_dma_en", 64'(dma_en), 64'(0));
    chk("rst_done", 64'(cmd_done), 64'(0));
    chk("rst_operands", 64'({funct3, sel_pim, size, mem_addr}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
  endtask

  initial begin
    int base_d;
    int base_e;
    rst_n = 1'b0;
    err_clr = 1'b0;
    cmd_if.i_cmd_valid = 1'b0;
    cmd_if.i_cmd_funct3 = 3'd0;
    cmd_if.i_cmd_sel_pim = 4'd0;
    cmd_if.i_cmd_size = 13'd0;
    cmd_if.i_cmd_addr = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset();

    // single command: strobe one cycle after accept, one completion, then idle
    busy_len = 40;
    base_d = done_cnt;
    send(3'b001, 4'd3, 13'd16, 32'h1000_0000, 1'b1);
    @(posedge clk);
    #1;
    chk("latency_en", 64'(dma_en), 64'(1));
    wait_done(base_d + 1, 200);
    repeat (10) @(posedge clk);
    #1;
    chk("single_done_cnt", 64'(done_cnt), 64'(base_d + 1));
    chk("single_idle", 64'(idle), 64'(1));
    chk("operands_held", 64'(size), 64'(16));

    // fill the FIFO behind a busy DMA; fifth command stalls until a slot frees
    busy_len = 30;
    base_d = done_cnt;
    send(3'b010, 4'd1, 13'd8, 32'h0000_0100, 1'b1);
    send(3'b100, 4'd2, 13'd9, 32'h0000_0200, 1'b1);
    send(3'b001, 4'd4, 13'd10, 32'h0000_0300, 1'b1);
    send(3'b010, 4'd5, 13'd11, 32'h0000_0400, 1'b1);
    chk("ready_after_3", 64'(cmd_if.o_cmd_ready), 64'(1));
    send(3'b100, 4'd6, 13'd12, 32'h0000_0500, 1'b1);
    chk("ready_after_4", 64'(cmd_if.o_cmd_ready), 64'(0));
    chk("full_after_4", 64'(q_full), 64'(1));
    send(3'b001, 4'd7, 13'd13, 32'h0000_0600, 1'b1);
    chk("stall_until_done", 64'(done_cnt), 64'(base_d + 1));
    wait_done(base_d + 6, 1500);
    chk("fill_sb_drained", 64'(sb.size()), 64'(0));

    // back-to-back: strobe exactly two cycles after each completion
    busy_len = 3;
    base_d = done_cnt;
    base_e = en_cnt;
    last_done_v = 1'b0;
    b2b_chk = 1'b1;
    send(3'b001, 4'd8, 13'd1, 32'hA000_0000, 1'b1);
    send(3'b010, 4'd9, 13'd2, 32'hA000_0040, 1'b1);
    send(3'b100, 4'd10, 13'd3, 32'hA000_0080, 1'b1);
    wait_done(base_d + 3, 300);
    b2b_chk = 1'b0;
    chk("b2b_en_cnt", 64'(en_cnt), 64'(base_e + 3));

    // push and pop in the same cycle with two entries queued
    busy_len = 10;
    base_d = done_cnt;
    send(3'b001, 4'd11, 13'd20, 32'hB000_0000, 1'b1);
    send(3'b010, 4'd12, 13'd21, 32'hB000_0010, 1'b1);
    send(3'b100, 4'd13, 13'd22, 32'hB000_0020, 1'b1);
    wait_done(base_d + 1, 200);
    @(posedge clk);
    #1;
    chk("pp_ready", 64'(cmd_if.o_cmd_ready), 64'(1));
    cmd_if.i_cmd_valid = 1'b1;
    cmd_if.i_cmd_funct3 = 3'b001;
    cmd_if.i_cmd_sel_pim = 4'd14;
    cmd_if.i_cmd_size = 13'd23;
    cmd_if.i_cmd_addr = 32'hB000_0030;
    sb.push_back('{f: 3'b001, s: 4'd14, z: 13'd23, a: 32'hB000_0030});
    @(posedge clk);
    #1;
    cmd_if.i_cmd_valid = 1'b0;
    chk("pp_full_occ2", 64'(q_full), 64'(0));
    send(3'b010, 4'd15, 13'd24, 32'hB000_0040, 1'b1);
    chk("pp_full_occ3", 64'(q_full), 64'(0));
    send(3'b100, 4'd0, 13'd25, 32'hB000_0050, 1'b1);
    chk("pp_full_occ4", 64'(q_full), 64'(1));
    wait_done(base_d + 6, 800);
    chk("wrap_empty", 64'(q_empty), 64'(1));
    chk("wrap_not_full", 64'(q_full), 64'(0));

    // reset while waiting on the DMA with three commands queued
    busy_len = 40;
    send(3'b001, 4'd1, 13'd30, 32'hC000_0000, 1'b1);
    send(3'b010, 4'd2, 13'd31, 32'hC000_0010, 1'b1);
    send(3'b100, 4'd3, 13'd32, 32'hC000_0020, 1'b1);
    send(3'b001, 4'd4, 13'd33, 32'hC000_0030, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(dma_busy), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    base_d = done_cnt;
    base_e = en_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    chk("post_rst_no_en", 64'(en_cnt), 64'(base_e));
    chk("post_rst_no_done", 64'(done_cnt), 64'(base_d));
    chk("post_rst_idle", 64'(idle), 64'(1));

`ifdef PIM_CMD_CHECK_EN
    // illegal opcode is dropped and flags the error; a legal one follows normally
    busy_len = 5;
    base_d = done_cnt;
    base_e = en_cnt;
    send(3'b011, 4'd5, 13'd4, 32'hD000_0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_err", 64'(err), 64'(1));
    chk("illegal_no_en", 64'(en_cnt), 64'(base_e));
    chk("illegal_idle", 64'(idle), 64'(1));
    send(3'b010, 4'd6, 13'd5, 32'hD000_0010, 1'b1);
    wait_done(base_d + 1, 200);
    chk("legal_en_cnt", 64'(en_cnt), 64'(base_e + 1));
    chk("err_sticky", 64'(err), 64'(1));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 64'(err), 64'(0));
`else
    // without checking, odd opcodes and zero size are forwarded unchanged
    busy_len = 5;
    base_d = done_cnt;
    base_e = en_cnt;
    send(3'b011, 4'd5, 13'd0, 32'hDEAD_BEEC, 1'b1);
    wait_done(base_d + 1, 200);
    chk("nochk_en_cnt", 64'(en_cnt), 64'(base_e + 1));
    chk("nochk_err", 64'(err), 64'(0));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("nochk_err_after_clr", 64'(err), 64'(0));
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_idle", 64'(idle), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
